// File: rtl/mux_n_to_1_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mux_n_to_1_stream : N-to-1 valid/ready stream mux, direct or round-robin grant,
//                     registered 1-cycle output stage.            Revision 1.0
// ============================================================================
module mux_n_to_1_stream #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    Clock,
  input  logic                    Reset_n,
  input  logic                    Mode,
  input  logic [SEL_W-1:0]        Select_Input,
  input  logic [NUM_CH*WIDTH-1:0] In_Data,
  input  logic [NUM_CH-1:0]       In_Valid,
  output logic [NUM_CH-1:0]       In_Ready,
  output logic [WIDTH-1:0]        Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic [SEL_W-1:0]        Out_Channel
);

  localparam logic [0:0]       EMPTY   = 1'b0;
  localparam logic [0:0]       FULL    = 1'b1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // Grant selection; out-of-range indices can never win in either mode
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (!Mode) begin
      if ((int'(Select_Input) < NUM_CH) && In_Valid[Select_Input]) begin
        grant       = Select_Input;
        grant_valid = 1'b1;
      end
    end else begin
      // Search starts just after the last winner, so it is checked last
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_CH) begin
          idx = idx - NUM_CH;
        end
        if (!grant_valid && In_Valid[SEL_W'(idx)]) begin
          grant       = SEL_W'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == SEL_W'(i)) begin
        sel_data = In_Data[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ready
      assign In_Ready[i] = xfer & (grant == SEL_W'(i));
    end
  endgenerate

  // Output-stage FSM: state register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output-stage FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   state_next = xfer ? FULL : EMPTY;
      FULL:    state_next = (xfer || !Out_Ready) ? FULL : EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Output-stage FSM: outputs
  always_comb begin
    Out_Valid = (state == FULL);
    load_en   = !Out_Valid || Out_Ready;
    xfer      = load_en && grant_valid;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Out_Data    <= '0;
      Out_Channel <= '0;
      last_grant  <= LAST_CH;
    end else if (xfer) begin
      Out_Data    <= sel_data;
      Out_Channel <= grant;
      if (Mode) begin
        last_grant <= grant;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_to_1_stream.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mux_n_to_1_stream : directed scenarios plus a random phase, scoreboarded
// against a small reference model of the grant and output stage.
module tb_mux_n_to_1_stream;

  localparam int WIDTH  = 32;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  logic                    Clock;
  logic                    Reset_n;
  logic                    Mode;
  logic [SEL_W-1:0]        Select_Input;
  logic [NUM_CH*WIDTH-1:0] In_Data;
  logic [NUM_CH-1:0]       In_Valid;
  logic [NUM_CH-1:0]       In_Ready;
  logic [WIDTH-1:0]        Out_Data;
  logic                    Out_Valid;
  logic                    Out_Ready;
  logic [SEL_W-1:0]        Out_Channel;

  mux_n_to_1_stream #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .Mode         (Mode),
    .Select_Input (Select_Input),
    .In_Data      (In_Data),
    .In_Valid     (In_Valid),
    .In_Ready     (In_Ready),
    .Out_Data     (Out_Data),
    .Out_Valid    (Out_Valid),
    .Out_Ready    (Out_Ready),
    .Out_Channel  (Out_Channel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
  } word_t;

  word_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model evaluated mid-cycle while inputs are stable
  logic             m_full;
  logic [SEL_W-1:0] m_last;

  always @(negedge Clock) begin
    logic             gv;
    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] idx;
    logic             le;
    logic [NUM_CH-1:0] exp_rdy;
    word_t            w;
    if (!Reset_n) begin
      m_full = 1'b0;
      m_last = SEL_W'(NUM_CH - 1);
      sb.delete();
      check("rst_out_valid", Out_Valid, 0);
      check("rst_out_data", Out_Data, 0);
    end else begin
      gv = 1'b0;
      g  = '0;
      if (!Mode) begin
        if (In_Valid[Select_Input]) begin
          gv = 1'b1;
          g  = Select_Input;
        end
      end else begin
        for (int k = 1; k <= NUM_CH; k++) begin
          idx = m_last + k[SEL_W-1:0];
          if (!gv && In_Valid[idx]) begin
            gv = 1'b1;
            g  = idx;
          end
        end
      end
      le      = !m_full || Out_Ready;
      exp_rdy = (le && gv) ? (NUM_CH'(1) << g) : '0;
      check("sb_in_ready", In_Ready, exp_rdy);
      check("sb_out_valid", Out_Valid, m_full);
      if (m_full && sb.size() > 0) begin
        check("sb_out_data", Out_Data, sb[0].data);
        check("sb_out_channel", Out_Channel, sb[0].ch);
        if (Out_Ready) void'(sb.pop_front());
      end
      if (le && gv) begin
        w.ch   = g;
        w.data = In_Data[int'(g)*WIDTH +: WIDTH];
        sb.push_back(w);
        if (Mode) m_last = g;
        m_full = 1'b1;
      end else if (Out_Ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [WIDTH-1:0] d);
    In_Data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n      = 1'b0;
    Mode         = 1'b0;
    Select_Input = 3'd5;
    In_Data      = '0;
    In_Valid     = 8'h20;
    Out_Ready    = 1'b1;
    set_ch(5, 32'hDEADBEEF);

    // 1: direct select of channel 5 straight out of reset
    repeat (2) tick();
    check("reset_out_valid", Out_Valid, 0);
    check("reset_out_data", Out_Data, 0);
    check("reset_out_channel", Out_Channel, 0);
    Reset_n = 1'b1;
    #1;
    check("t1_in_ready", In_Ready, 8'h20);
    tick();
    In_Valid = 8'h00;
    check("t1_out_valid", Out_Valid, 1);
    check("t1_out_data", Out_Data, 32'hDEADBEEF);
    check("t1_out_channel", Out_Channel, 5);
    tick();
    check("t1_drained", Out_Valid, 0);

    // 2: round-robin over all channels, one word per cycle
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 32'hA000_0000 + i);
    Mode     = 1'b1;
    In_Valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 9) In_Valid = 8'h00;
      check("t2_valid", Out_Valid, 1);
      check("t2_channel", Out_Channel, k % NUM_CH);
      check("t2_data", Out_Data, 32'hA000_0000 + (k % NUM_CH));
    end
    tick();
    check("t2_drained", Out_Valid, 0);

    // 3: two sparse requesters, wrap 7 -> 0
    apply_reset();
    Mode     = 1'b1;
    In_Valid = 8'h81;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) In_Valid = 8'h00;
      check("t3_channel", Out_Channel, (k % 2 == 0) ? 0 : 7);
    end
    tick();

    // 4: stall with a full output while channel 2 waits
    Mode         = 1'b0;
    Select_Input = 3'd1;
    set_ch(1, 32'h11111111);
    set_ch(2, 32'h22222222);
    In_Valid     = 8'h02;
    tick();
    Out_Ready    = 1'b0;
    Select_Input = 3'd2;
    In_Valid     = 8'h04;
    #1;
    check("t4_ready_stalled", In_Ready, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_hold_data", Out_Data, 32'h11111111);
      check("t4_hold_ready", In_Ready, 8'h00);
    end
    Out_Ready = 1'b1;
    #1;
    check("t4_ready_release", In_Ready, 8'h04);
    tick();
    In_Valid = 8'h00;
    check("t4_new_data", Out_Data, 32'h22222222);
    check("t4_new_channel", Out_Channel, 2);
    tick();
    check("t4_no_duplicate", Out_Valid, 0);

    // 5: selected channel not valid, then becomes valid
    Select_Input = 3'd3;
    set_ch(3, 32'h33333333);
    In_Valid     = 8'hF7;
    #1;
    check("t5_no_ready", In_Ready, 8'h00);
    repeat (2) begin
      tick();
      check("t5_idle", Out_Valid, 0);
    end
    In_Valid = 8'hFF;
    #1;
    check("t5_ready", In_Ready, 8'h08);
    tick();
    In_Valid = 8'h00;
    check("t5_channel", Out_Channel, 3);
    check("t5_data", Out_Data, 32'h33333333);
    tick();

    // 6: async reset while full with pointer at 4
    Mode     = 1'b1;
    set_ch(4, 32'h44444444);
    In_Valid = 8'h10;
    tick();
    In_Valid  = 8'h00;
    Out_Ready = 1'b0;
    check("t6_loaded", Out_Channel, 4);
    #2;
    Reset_n = 1'b0;
    #1;
    check("t6_rst_valid", Out_Valid, 0);
    check("t6_rst_data", Out_Data, 0);
    check("t6_rst_channel", Out_Channel, 0);
    tick();
    Reset_n   = 1'b1;
    Out_Ready = 1'b1;
    In_Valid  = 8'hFF;
    #1;
    check("t6_first_grant", In_Ready, 8'h01);
    tick();
    In_Valid = 8'h00;
    check("t6_channel", Out_Channel, 0);
    tick();

    // Random phase, checked by the scoreboard
    for (int k = 0; k < 300; k++) begin
      Mode         = 1'($urandom_range(0, 1));
      Select_Input = 3'($urandom_range(0, 7));
      In_Valid     = 8'($urandom);
      Out_Ready    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) set_ch(i, $urandom);
      tick();
    end
    In_Valid  = 8'h00;
    Out_Ready = 1'b1;
    repeat (2) tick();
    check("final_drained", Out_Valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
